fifo_alu_ctrl: RTL and testbench
================================

# fifo_alu_ctrl

Command sequencer between the UART receive FIFO, the combinational ALU and the UART transmit FIFO. It pops three bytes from the RX FIFO (operand A, operand B, opcode) and drives them to the ALU as registered values. It then captures the ALU result and pushes it into the TX FIFO. An inter-byte timeout discards stale partial commands, so a lost byte cannot desynchronise the stream.

## Interface
Parameters:
- DATA_W, 8, width of FIFO words, ALU operands and result
- OP_W, 6, opcode width; taken from the low OP_W bits of the third byte
- TIMEOUT, 1_000_000, max clk cycles waiting for byte 2 or 3 of a command; 0 disables timeout

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- rx_empty  in  1  RX FIFO empty flag
- rx_data  in  DATA_W  RX FIFO head word (valid whenever !rx_empty)
- rx_rd  out  1  RX FIFO pop strobe, one cycle per byte
- tx_full  in  1  TX FIFO full flag
- tx_wr  out  1  TX FIFO push strobe
- tx_data  out  DATA_W  word to push; equals result register
- alu_a  out  DATA_W  operand A register
- alu_b  out  DATA_W  operand B register
- alu_op  out  OP_W  opcode register
- alu_result  in  DATA_W  combinational ALU output
- busy  out  1  high in every state except GET_A
- done  out  1  one-cycle pulse, coincident with tx_wr
- timeout_err  out  1  one-cycle pulse when a partial command is dropped

## Operation
- States: GET_A, GET_B, GET_OP, EXEC, SEND. Reset state is GET_A.
- GET_A/GET_B/GET_OP: when !rx_empty, the block asserts rx_rd combinationally in the same cycle, latches rx_data into the matching register (alu_op gets rx_data[OP_W-1:0]) and advances. When rx_empty, it holds and rx_rd=0.
- EXEC: one cycle. The block latches alu_result into res_reg and goes to SEND. rx_rd=0.
- SEND: tx_data=res_reg always. When !tx_full, tx_wr=1 and done=1, then go to GET_A. When tx_full, hold with tx_wr=0, with no timeout and no drop.
- Timeout: the counter clears on every rx_rd and counts while in GET_B or GET_OP with rx_empty. On reaching TIMEOUT-1 the block pulses timeout_err, goes to GET_A and leaves the A/B/op registers unchanged. If rx_empty deasserts in that same cycle, the timeout wins and no pop occurs.
- Operand registers change only on their own pop; between commands they keep their last values.
- The block never asserts rx_rd and tx_wr in the same cycle.

## Timing
- Reset values: state=GET_A, alu_a=alu_b=0, alu_op=0, res_reg=0 (tx_data=0), rx_rd=tx_wr=done=timeout_err=0, busy=0, counter=0.
- reset_n asserted mid-command drops the partial command immediately, with no tx_wr. After release the block starts at GET_A on the next rising edge.
- Best-case latency, first pop to tx_wr, is 4 cycles: pops in cycles 0,1,2; EXEC in cycle 3; tx_wr in cycle 4. Back-to-back commands therefore need 5 cycles each.
- alu_a/alu_b/alu_op are stable from the cycle after the GET_OP pop through SEND. The ALU has one full cycle (EXEC) of combinational settling.
- rx_rd depends only on state and rx_empty. tx_wr depends only on state and tx_full.

## Structure
- Shared package fifo_alu_pkg holds the state encoding localparams (GET_A=0 … SEND=4, 3 bits) and the default DATA_W/OP_W. The ALU opcode constants already live there or go there.
- One sub-module, byte_timeout, holds the cycle counter. Its interface is clr, en, expire pulse, parameter TIMEOUT, width $clog2(TIMEOUT+1). It has no effect when TIMEOUT=0.
- The FSM uses one sequential block plus one combinational next-state/output block in the top module.

## Test plan
- Reset: hold reset_n=0 with FIFOs non-empty, then release. Required: all outputs 0, no rx_rd until the first edge after release, first pop in GET_A.
- Basic command: RX contains 0x05, 0x03, 0x20 and the ALU model is ADD. Required: three rx_rd pulses in consecutive cycles; alu_a=5, alu_b=3, alu_op=0x20; tx_wr with tx_data=0x08 four cycles after the first pop; done pulse in the same cycle.
- Gapped bytes: insert 10 empty cycles between B and op. Required: rx_rd held low during the gap, result correct, no timeout_err.
- TX backpressure: tx_full=1 for 20 cycles at SEND. Required: tx_data steady, tx_wr=0 and busy=1 throughout; single tx_wr on the first cycle tx_full=0; no extra pops while holding.
- Timeout: TIMEOUT=16, send only A and B. Required: timeout_err pulses 16 cycles after the second pop and the state returns to GET_A. Then send a full 3-byte command; its first byte is treated as A and the result is correct.
- Reset mid-command: assert reset_n=0 after the A pop. Required: no tx_wr, registers cleared, next 3-byte command processed normally.

Source files
------------

// File: rtl/fifo_alu_pkg.sv
// Shared definitions for the RX-FIFO -> ALU -> TX-FIFO command sequencer.
package fifo_alu_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned OP_W_DEF   = 6;
    localparam int unsigned STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_e;

    // ALU opcodes carried in the low bits of the third command byte
    localparam logic [OP_W_DEF-1:0] ALU_OP_ADD = 6'h20;
    localparam logic [OP_W_DEF-1:0] ALU_OP_SUB = 6'h22;
    localparam logic [OP_W_DEF-1:0] ALU_OP_AND = 6'h24;
    localparam logic [OP_W_DEF-1:0] ALU_OP_OR  = 6'h25;
    localparam logic [OP_W_DEF-1:0] ALU_OP_XOR = 6'h26;

    // States in which the inter-byte timeout is armed
    function automatic logic is_wait_state(state_e s);
        return (s == GET_B) || (s == GET_OP);
    endfunction

endpackage

// File: rtl/fifo_alu_ctrl_byte_timeout.sv
// Inter-byte cycle counter; expire pulses when the wait reaches TIMEOUT cycles.
module byte_timeout #(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned   CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit            ENABLED = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire = ENABLED && en && (cnt_q == LAST);

    // Counter restarts after every pop and after every expiry
    always_comb begin
        cnt_d = cnt_q;
        if (clr || expire || !ENABLED) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_alu_ctrl.sv
// Command sequencer: pops A, B, opcode from RX FIFO, runs the ALU, pushes result to TX FIFO.
module fifo_alu_ctrl
    import fifo_alu_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_empty,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_rd,
    input  logic              tx_full,
    output logic              tx_wr,
    output logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              run_q;
    logic              expire;

    byte_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_byte_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (rx_rd),
        .en      (is_wait_state(state_q)),
        .expire  (expire)
    );

    // Next-state and strobes; an expiring wait takes priority over a late byte
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        rx_rd       = 1'b0;
        tx_wr       = 1'b0;
        done        = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            GET_A: begin
                if (run_q && !rx_empty) begin
                    rx_rd   = 1'b1;
                    a_d     = rx_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (expire) begin
                    timeout_err = 1'b1;
                    state_d     = GET_A;
                end else if (!rx_empty) begin
                    rx_rd   = 1'b1;
                    b_d     = rx_data;
                    state_d = GET_OP;
                end
            end
            GET_OP: begin
                if (expire) begin
                    timeout_err = 1'b1;
                    state_d     = GET_A;
                end else if (!rx_empty) begin
                    rx_rd   = 1'b1;
                    op_d    = rx_data[OP_W-1:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                state_d = SEND;
            end
            SEND: begin
                if (!tx_full) begin
                    tx_wr   = 1'b1;
                    done    = 1'b1;
                    state_d = GET_A;
                end
            end
            default: begin
                state_d = GET_A;
            end
        endcase
    end

    // run_q keeps the first pop off the cycle in which reset is released
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            run_q   <= 1'b1;
        end
    end

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_op  = op_q;
    assign tx_data = res_q;
    assign busy    = (state_q != GET_A);

endmodule

// File: tb/tb_fifo_alu_ctrl.sv
// Self-checking bench: bench-side FIFOs and ALU, scoreboard of expected results per command.
module tb_fifo_alu_ctrl;
    import fifo_alu_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned OW = 6;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rx_empty;
    logic [DW-1:0] rx_data;
    logic          rx_rd;
    logic          tx_full;
    logic          tx_wr;
    logic [DW-1:0] tx_data;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [OW-1:0] alu_op;
    logic [DW-1:0] alu_result;
    logic          busy;
    logic          done;
    logic          timeout_err;

    always #5 clk = ~clk;

    fifo_alu_ctrl #(
        .DATA_W  (DW),
        .OP_W    (OW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_empty    (rx_empty),
        .rx_data     (rx_data),
        .rx_rd       (rx_rd),
        .tx_full     (tx_full),
        .tx_wr       (tx_wr),
        .tx_data     (tx_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    function automatic logic [DW-1:0] alu_f(logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op);
        case (op)
            ALU_OP_SUB: return a - b;
            ALU_OP_AND: return a & b;
            ALU_OP_OR:  return a | b;
            ALU_OP_XOR: return a ^ b;
            default:    return a + b;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] op;
        logic [DW-1:0] res;
    } exp_t;

    exp_t          exq[$];
    logic [DW-1:0] rxq[$];
    bit            rx_stall;
    int            n_chk;
    int            n_pass;
    int            n_rd;
    logic          s_rd, s_wr, s_done, s_to, s_busy;
    logic [DW-1:0] s_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void refresh();
        rx_empty = rx_stall || (rxq.size() == 0);
        rx_data  = (rxq.size() != 0) ? rxq[0] : '0;
    endfunction

    function automatic void expect_cmd(logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] c);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.op  = c[OW-1:0];
        e.res = alu_f(a, b, c[OW-1:0]);
        exq.push_back(e);
    endfunction

    function automatic void push_cmd(logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] c, bit expect_it);
        rxq.push_back(a);
        rxq.push_back(b);
        rxq.push_back(c);
        if (expect_it) expect_cmd(a, b, c);
        refresh();
    endfunction

    // One clock: sample at negedge, score any push, then apply the pop after the edge
    task automatic step();
        exp_t e;
        @(negedge clk);
        s_rd   = rx_rd;
        s_wr   = tx_wr;
        s_done = done;
        s_to   = timeout_err;
        s_busy = busy;
        s_data = tx_data;
        if (s_rd || s_wr) check("rd_wr_excl", 64'(s_rd & s_wr), 64'd0);
        if (s_wr || s_done) check("done_eq_wr", 64'(s_done), 64'(s_wr));
        if (s_wr) begin
            if (exq.size() == 0) begin
                check("tx_unexpected", 64'd1, 64'd0);
            end else begin
                e = exq.pop_front();
                check("tx_data", 64'(s_data), 64'(e.res));
                check("tx_operands", 64'({alu_a, alu_b, alu_op}), 64'({e.a, e.b, e.op}));
            end
        end
        @(posedge clk);
        #1;
        if (s_rd) begin
            n_rd++;
            if (rxq.size() != 0) void'(rxq.pop_front());
        end
        refresh();
    endtask

    task automatic wait_pops(input int n, input int budget);
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (s_rd) got++;
            if (got == n) return;
        end
        check("wait_pops_bound", 64'(got), 64'(n));
    endtask

    task automatic wait_tx(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (s_wr) return;
        end
        check("wait_tx_bound", 64'd0, 64'd1);
    endtask

    initial begin
        int to_k;
        int rd_base;
        int guard;
        n_chk    = 0;
        n_pass   = 0;
        n_rd     = 0;
        reset_n  = 1'b0;
        tx_full  = 1'b0;
        rx_stall = 1'b0;
        push_cmd(8'h05, 8'h03, 8'h20, 1'b1);

        // Reset held with RX non-empty
        repeat (3) begin
            step();
            check("rst_outs", 64'({s_rd, s_wr, s_done, s_to, s_busy}), 64'd0);
            check("rst_regs", 64'({alu_a, alu_b, alu_op, tx_data}), 64'd0);
        end
        reset_n = 1'b1;
        step();
        check("rel_no_rd", 64'(s_rd), 64'd0);

        // Basic ADD command, best-case latency
        for (int i = 0; i < 3; i++) begin
            step();
            check("pop_consec", 64'(s_rd), 64'd1);
        end
        check("basic_regs", 64'({alu_a, alu_b, alu_op}), 64'({8'h05, 8'h03, 6'h20}));
        step();
        check("exec_idle", 64'({s_rd, s_wr}), 64'd0);
        step();
        check("send_wr", 64'(s_wr), 64'd1);
        check("send_done", 64'(s_done), 64'd1);
        check("send_data", 64'(s_data), 64'h08);

        // Gap of 10 empty cycles before the opcode byte
        rxq.push_back(8'h9C);
        rxq.push_back(8'h21);
        expect_cmd(8'h9C, 8'h21, 8'hE2);
        refresh();
        wait_pops(2, 10);
        for (int i = 0; i < 10; i++) begin
            step();
            check("gap_quiet", 64'({s_rd, s_to}), 64'd0);
        end
        rxq.push_back(8'hE2);
        refresh();
        step();
        check("gap_pop", 64'(s_rd), 64'd1);
        wait_tx(5);

        // TX backpressure for 20 cycles at SEND with the next command waiting
        tx_full = 1'b1;
        push_cmd(8'h3C, 8'h0F, 8'h24, 1'b1);
        push_cmd(8'h11, 8'h22, 8'h25, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_pop", 64'(s_rd), 64'd1);
        end
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_hold", 64'({s_rd, s_wr, s_done}), 64'd0);
            check("bp_busy", 64'(s_busy), 64'd1);
            check("bp_data", 64'(s_data), 64'h0C);
        end
        tx_full = 1'b0;
        step();
        check("bp_release", 64'(s_wr), 64'd1);
        step();
        check("bp_single", 64'(s_wr), 64'd0);
        wait_tx(8);

        // Timeout after A and B only
        rxq.push_back(8'h77);
        rxq.push_back(8'h12);
        refresh();
        wait_pops(2, 10);
        to_k = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (s_to) begin
                to_k = k;
                break;
            end
        end
        check("to_latency", 64'(to_k), 64'(TO));
        check("to_regs_kept", 64'({alu_a, alu_b, alu_op}), 64'({8'h77, 8'h12, 6'h25}));
        step();
        check("to_idle", 64'({s_busy, s_wr}), 64'd0);
        push_cmd(8'h50, 8'h0A, 8'h20, 1'b1);
        wait_tx(10);

        // Byte arriving in the expiry cycle: timeout wins, byte becomes next A
        rxq.push_back(8'h01);
        rxq.push_back(8'h02);
        refresh();
        wait_pops(2, 10);
        for (int i = 0; i < TO - 1; i++) begin
            step();
            check("tw_wait", 64'({s_rd, s_to}), 64'd0);
        end
        rxq.push_back(8'h26);
        refresh();
        step();
        check("tw_to", 64'(s_to), 64'd1);
        check("tw_no_pop", 64'(s_rd), 64'd0);
        rxq.push_back(8'h13);
        rxq.push_back(8'h26);
        expect_cmd(8'h26, 8'h13, 8'h26);
        refresh();
        wait_tx(10);

        // Reset after the A pop
        push_cmd(8'hAA, 8'h55, 8'h20, 1'b0);
        step();
        check("rm_popA", 64'(s_rd), 64'd1);
        reset_n = 1'b0;
        rxq.delete();
        refresh();
        step();
        check("rm_outs", 64'({s_rd, s_wr, s_busy}), 64'd0);
        check("rm_regs", 64'({alu_a, alu_b, alu_op, tx_data}), 64'd0);
        reset_n = 1'b1;
        step();
        push_cmd(8'h0F, 8'hF0, 8'h25, 1'b1);
        wait_tx(10);

        // Random commands with random RX stalls and TX backpressure
        rd_base = n_rd;
        for (int i = 0; i < 30; i++) begin
            push_cmd(DW'($urandom), DW'($urandom), DW'($urandom), 1'b1);
        end
        guard = 0;
        while (exq.size() != 0 && guard < 3000) begin
            rx_stall = ($urandom_range(0, 3) == 0);
            tx_full  = ($urandom_range(0, 2) == 0);
            refresh();
            step();
            guard++;
        end
        rx_stall = 1'b0;
        tx_full  = 1'b0;
        refresh();
        check("rand_drained", 64'(exq.size()), 64'd0);
        check("rand_pops", 64'(n_rd - rd_base), 64'd90);
        check("rx_consumed", 64'(rxq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
